// File: rtl/cla_seq_pkg.sv
// Shared definitions for the sequential carry-lookahead adder controller.
//   NIBBLE_W : width of the lookahead slice
//   state_t  : controller state encoding
package cla_seq_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit generate/propagate carry-lookahead adder slice.
// Ports:
//   a, b : 4-bit addends
//   cin  : carry into bit 0
//   s    : 4-bit sum
//   cout : carry out of bit 3
module cla4_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);

   logic [3:0] g;
   logic [3:0] p;
   logic [3:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // All carries are flattened from g/p/cin so none depends on a lower carry.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & cin);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s = p ^ c;

endmodule

// File: rtl/cla_seq_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder: one 4-bit lookahead slice is stepped over the
// operands a nibble per clock, LSB nibble first, with the carry registered
// between passes. Valid/ready on both the request and result sides.
// Optional feature macro: CLA_SEQ_OVF_EN adds a registered signed-overflow
// output OVF.
// Ports:
//   CLK, RST_N          : clock, synchronous active-low reset
//   IN_VALID, IN_READY  : request handshake, A/B/C_IN captured in IDLE
//   A, B, C_IN          : operands and carry into bit 0
//   OUT_VALID, OUT_READY: result handshake
//   S, C_OUT            : registered sum and carry out of bit WIDTH-1
//   BUSY                : operation in progress or result pending
//   OVF                 : signed overflow (CLA_SEQ_OVF_EN only)
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | ready for a request; captures operands on IN_VALID
// ST_RUN  | one nibble per clock through the slice
// ST_DONE | result presented, held until OUT_READY
module cla_seq_adder_ctrl
   import cla_seq_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C_IN,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] S,
   output logic             C_OUT,
`ifdef CLA_SEQ_OVF_EN
   output logic             OVF,
`endif
   output logic             BUSY
);

   localparam int NIBBLES = WIDTH / NIBBLE_W;
   localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_check
      $error("cla_seq_adder_ctrl: WIDTH must be a non-zero multiple of 4");
   end

   state_t             state_q;
   state_t             state_d;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   s_q;
   logic               carry_q;
   logic               c_out_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               last_nib;
   logic [NIBBLE_W-1:0] slice_s;
   logic               slice_cout;

   assign last_nib = (cnt_q == CNT_W'(NIBBLES - 1));

   cla4_slice u_slice (
      .a    (a_q[NIBBLE_W*int'(cnt_q) +: NIBBLE_W]),
      .b    (b_q[NIBBLE_W*int'(cnt_q) +: NIBBLE_W]),
      .cin  (carry_q),
      .s    (slice_s),
      .cout (slice_cout)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      IN_READY  = 1'b0;
      OUT_VALID = 1'b0;
      BUSY      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            IN_READY = 1'b1;
            if (IN_VALID) state_d = ST_RUN;
         end
         ST_RUN: begin
            BUSY = 1'b1;
            if (last_nib) state_d = ST_DONE;
         end
         ST_DONE: begin
            BUSY      = 1'b1;
            OUT_VALID = 1'b1;
            if (OUT_READY) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         carry_q <= 1'b0;
         c_out_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (IN_VALID) begin
                  a_q     <= A;
                  b_q     <= B;
                  carry_q <= C_IN;
                  s_q     <= '0;
                  cnt_q   <= '0;
               end
            end
            ST_RUN: begin
               s_q[NIBBLE_W*int'(cnt_q) +: NIBBLE_W] <= slice_s;
               carry_q <= slice_cout;
               if (last_nib) begin
                  c_out_q <= slice_cout;
                  cnt_q   <= '0;
               end else begin
                  cnt_q   <= cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CLA_SEQ_OVF_EN
   logic ovf_q;

   // A^B^S at the MSB recovers the carry into the MSB; xor with carry out.
   always_ff @(posedge CLK) begin
      if (!RST_N)
         ovf_q <= 1'b0;
      else if (state_q == ST_RUN && last_nib)
         ovf_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_s[NIBBLE_W-1] ^ slice_cout;
   end

   assign OVF = ovf_q;
`endif

   assign S     = s_q;
   assign C_OUT = c_out_q;

endmodule

// File: tb/tb_cla_seq_adder_ctrl.sv
// Scoreboard bench for cla_seq_adder_ctrl (WIDTH=16). Stimulus pushes the
// hand-computed result and the cycle it must appear on; a monitor pops and
// compares on every rising OUT_VALID.
module tb_cla_seq_adder_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        IN_VALID = 1'b0;
   logic        IN_READY;
   logic [15:0] A = '0;
   logic [15:0] B = '0;
   logic        C_IN = 1'b0;
   logic        OUT_VALID;
   logic        OUT_READY = 1'b1;
   logic [15:0] S;
   logic        C_OUT;
   logic        BUSY;
`ifdef CLA_SEQ_OVF_EN
   logic        OVF;
`endif

   cla_seq_adder_ctrl #(.WIDTH(16)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .A         (A),
      .B         (B),
      .C_IN      (C_IN),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .S         (S),
      .C_OUT     (C_OUT),
`ifdef CLA_SEQ_OVF_EN
      .OVF       (OVF),
`endif
      .BUSY      (BUSY)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0] s;
      logic        c;
      logic        ovf;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   logic ov_prev  = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge CLK) begin
      if (OUT_VALID && !ov_prev) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_out_valid: got S=%0h C_OUT=%0b expected no result", S, C_OUT);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("sum", 32'(S), 32'(e.s));
            check("c_out", 32'(C_OUT), 32'(e.c));
            check("latency_cycle", 32'(cyc), 32'(e.cyc));
`ifdef CLA_SEQ_OVF_EN
            check("ovf", 32'(OVF), 32'(e.ovf));
`endif
         end
      end
      ov_prev = OUT_VALID;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [15:0] s_exp, input logic c_exp, input logic ovf_exp,
                        input bit expect_result);
      exp_t e;
      check("in_ready_at_issue", 32'(IN_READY), 32'd1);
      A = a; B = b; C_IN = cin; IN_VALID = 1'b1;
      tick();
      IN_VALID = 1'b0;
      if (expect_result) begin
         e.s = s_exp; e.c = c_exp; e.ovf = ovf_exp; e.cyc = cyc + 4;
         q.push_back(e);
      end
      check("busy_in_run", 32'(BUSY), 32'd1);
      check("in_ready_in_run", 32'(IN_READY), 32'd0);
   endtask

   task automatic wait_out();
      for (int i = 0; i < 30 && !OUT_VALID; i++) tick();
      check("out_valid_within_bound", 32'(OUT_VALID), 32'd1);
   endtask

   task automatic finish_op();
      wait_out();
      tick();
      check("idle_out_valid", 32'(OUT_VALID), 32'd0);
      check("idle_in_ready", 32'(IN_READY), 32'd1);
      check("idle_busy", 32'(BUSY), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held with a request pending: nothing may be captured.
      RST_N = 1'b0; IN_VALID = 1'b1; A = 16'hFFFF; B = 16'hFFFF; C_IN = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_in_ready", 32'(IN_READY), 32'd1);
         check("rst_out_valid", 32'(OUT_VALID), 32'd0);
         check("rst_s", 32'(S), 32'd0);
         check("rst_c_out", 32'(C_OUT), 32'd0);
         check("rst_busy", 32'(BUSY), 32'd0);
`ifdef CLA_SEQ_OVF_EN
         check("rst_ovf", 32'(OVF), 32'd0);
`endif
      end
      IN_VALID = 1'b0;
      RST_N = 1'b1;
      tick();
      check("post_rst_idle", 32'(BUSY), 32'd0);

      OUT_READY = 1'b1;
      issue(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
      finish_op();
      issue(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 1'b1);
      finish_op();
      issue(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
      finish_op();
      issue(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
      finish_op();

      // Backpressure with competing requests during RUN and DONE.
      OUT_READY = 1'b0;
      issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
      A = 16'h1111; B = 16'h1111; C_IN = 1'b1; IN_VALID = 1'b1;
      wait_out();
      for (int i = 0; i < 10; i++) begin
         tick();
         check("stall_out_valid", 32'(OUT_VALID), 32'd1);
         check("stall_s", 32'(S), 32'h0000);
         check("stall_c_out", 32'(C_OUT), 32'd1);
         check("stall_in_ready", 32'(IN_READY), 32'd0);
      end
      IN_VALID = 1'b0;
      OUT_READY = 1'b1;
      tick();
      check("release_out_valid", 32'(OUT_VALID), 32'd0);
      check("release_in_ready", 32'(IN_READY), 32'd1);
      issue(16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0, 1'b0, 1'b1);
      finish_op();

      // Reset on the second RUN cycle aborts the operation.
      issue(16'hABCD, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      tick();
      RST_N = 1'b0;
      tick();
      check("abort_in_ready", 32'(IN_READY), 32'd1);
      check("abort_busy", 32'(BUSY), 32'd0);
      check("abort_out_valid", 32'(OUT_VALID), 32'd0);
      check("abort_s", 32'(S), 32'd0);
      check("abort_c_out", 32'(C_OUT), 32'd0);
      RST_N = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      check("abort_no_result", 32'(OUT_VALID), 32'd0);
      issue(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
      finish_op();

      tick();
      check("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
